// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder slice:
//   - state encoding of the responder FSM (IDLE=0, WAIT=1, ACCESS=2, DONE=3)
//   - default data / address widths and array depth
//   - legal maximum for WAIT_STATES and the wait counter width that holds it
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   localparam int DEF_DATA_W      = 16;
   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_DEPTH       = 1024;
   localparam int WAIT_STATES_MAX = 15;
   localparam int CNT_W           = 4;   // holds 0..WAIT_STATES_MAX

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Synchronous single-port DEPTH x DATA_W storage with a registered read port.
// The storage itself is not reset; only the read register is.
// Ports:
//   CLK    in   clock
//   Reset  in   async active-high reset (read register only)
//   we     in   write enable: wdata -> mem[idx] at the rising edge
//   re     in   read enable: mem[idx] -> rdata at the rising edge
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Storage write port; contents are intentionally left unreset.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem_r[idx] <= wdata;
      end
   end

   // Read register: loads only on a read so it holds across writes and idle time.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         rdata_r <= {DATA_W{1'b0}};
      end else if (re) begin
         rdata_r <= mem_r[idx];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the multicycle datapath memory port. Accepts a
// single-word read/write request in IDLE, waits WAIT_STATES cycles, performs
// the access in ACCESS and pulses Ready for one cycle in DONE.
// Optional feature: define MEM_RESP_RANGE_CHECK_EN to flag addresses with any
// bit at or above log2(DEPTH) set as faults (Err with Ready, no array access).
// Without it the upper address bits are ignored and Err stays 0.
// Ports:
//   CLK    in   clock
//   Reset  in   async active-high reset
//   Req    in   request strobe, sampled only in IDLE
//   We     in   1 = write, 0 = read
//   Addr   in   word address
//   WData  in   write data
//   RData  out  registered read data
//   Ready  out  one-cycle completion pulse
//   Busy   out  request in progress
//   Err    out  address fault, valid with Ready
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Req,
   input  logic              We,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic [DATA_W-1:0] RData,
   output logic              Ready,
   output logic              Busy,
   output logic              Err
);

   localparam int IDX_W = $clog2(DEPTH);

   // First WAIT cycle already counts as one wait state, hence WAIT_STATES-1.
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES == 0) ? {CNT_W{1'b0}}
                                                              : CNT_W'(WAIT_STATES - 32'sd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef MEM_RESP_RANGE_CHECK_EN
   localparam logic RANGE_CHECK_EN = 1'b1;
`else
   localparam logic RANGE_CHECK_EN = 1'b0;
`endif

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic              req_we_r;
   logic [DATA_W-1:0] req_wdata_r;
   logic              ready_r;
   logic              busy_r;
   logic              err_r;

   logic [ADDR_W-1:0] addr_hi_s;
   logic              fault_s;
   logic              mem_we_s;
   logic              mem_re_s;

   // Range check on the latched address; disabled builds mask it to 0.
   always_comb begin
      addr_hi_s = req_addr_r >> IDX_W;
      fault_s   = RANGE_CHECK_EN & (addr_hi_s != {ADDR_W{1'b0}});
   end

   // Array strobes: the access happens on the edge that leaves ACCESS.
   always_comb begin
      mem_we_s = 1'b0;
      mem_re_s = 1'b0;
      if (state_r == ACCESS) begin
         mem_we_s = req_we_r & ~fault_s;
         mem_re_s = ~req_we_r & ~fault_s;
      end else begin
         mem_we_s = 1'b0;
         mem_re_s = 1'b0;
      end
   end

   // Responder FSM with request registers, wait counter and registered flags.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         req_addr_r  <= {ADDR_W{1'b0}};
         req_we_r    <= 1'b0;
         req_wdata_r <= {DATA_W{1'b0}};
         ready_r     <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               if (Req) begin
                  req_addr_r  <= Addr;
                  req_we_r    <= We;
                  req_wdata_r <= WData;
                  busy_r      <= 1'b1;
                  if (WAIT_STATES == 0) begin
                     state_r <= ACCESS;
                  end else begin
                     state_r <= WAIT;
                     cnt_r   <= CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt_r == {CNT_W{1'b0}}) begin
                  state_r <= ACCESS;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ACCESS: begin
               state_r <= DONE;
               ready_r <= 1'b1;
               err_r   <= fault_s;
            end
            DONE: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem_array (
      .CLK   (CLK),
      .Reset (Reset),
      .we    (mem_we_s),
      .re    (mem_re_s),
      .idx   (req_addr_r[IDX_W-1:0]),
      .wdata (req_wdata_r),
      .rdata (RData)
   );

   assign Ready = ready_r;
   assign Busy  = busy_r;
   assign Err   = err_r;

endmodule
